// File: rtl/usb_echo_ctrl.sv
// Host loopback sequencer for usb_ctrl: issues read/write transfer requests and
// echoes every word received from the host OUT FIFO back through the IN FIFO.
module usb_echo_ctrl #(
  parameter int PKT_WORDS = 4,
  parameter int ADDR_W    = 4,
  parameter int TO_CYC    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        echo_en,
  input  logic        usb_is_busy,
  input  logic [15:0] read_data,
  input  logic        output_valid,
  input  logic        write_ready,
  output logic [10:0] rd_wr_num,
  output logic [1:0]  rd_wr_en,
  output logic [15:0] write_data,
  output logic [15:0] pkt_cnt,
  output logic [2:0]  err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW    = $clog2(TO_CYC + 1);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PKT_C   = (ADDR_W + 1)'(PKT_WORDS);
  localparam logic [TW-1:0]   TO_LAST = TW'(TO_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] rp_q, rp_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              seen_busy_q, seen_busy_d;
  logic [1:0]        rd_wr_en_q, rd_wr_en_d;
  logic [10:0]       rd_wr_num_q, rd_wr_num_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [2:0]        err_q, err_d;
  logic [15:0]       mem_q [DEPTH];

  logic              push_ok;
  logic              pop_ok;
  logic [ADDR_W:0]   free_words;
  logic [ADDR_W:0]   wr_words;

  always_comb begin
    push_ok     = output_valid && (count_q != DEPTH_C);
    pop_ok      = write_ready && (count_q != '0);
    free_words  = DEPTH_C - count_q;
    wr_words    = (count_q < PKT_C) ? count_q : PKT_C;

    state_d     = state_q;
    timer_d     = timer_q;
    seen_busy_d = seen_busy_q;
    rd_wr_en_d  = 2'b00;
    rd_wr_num_d = rd_wr_num_q;
    pkt_cnt_d   = pkt_cnt_q;

    // Full/empty faults are judged on the count before this cycle's push/pop.
    err_d       = err_q;
    if (output_valid && (count_q == DEPTH_C)) err_d[0] = 1'b1;
    if (write_ready && (count_q == '0))       err_d[1] = 1'b1;

    wp_d    = push_ok ? wp_q + 1'b1 : wp_q;
    rp_d    = pop_ok  ? rp_q + 1'b1 : rp_q;
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (!usb_is_busy && (count_q != '0)) begin
          state_d     = WR_REQ;
          rd_wr_en_d  = 2'b01;
          rd_wr_num_d = 11'(wr_words);
        end else if (!usb_is_busy && echo_en && (free_words >= PKT_C)) begin
          state_d     = RD_REQ;
          rd_wr_en_d  = 2'b10;
          rd_wr_num_d = 11'(PKT_C);
        end
      end
      RD_REQ, WR_REQ: begin
        state_d     = (state_q == RD_REQ) ? RD_WAIT : WR_WAIT;
        timer_d     = '0;
        seen_busy_d = 1'b0;
      end
      RD_WAIT, WR_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (usb_is_busy) seen_busy_d = 1'b1;
        if (seen_busy_q && !usb_is_busy) begin
          state_d = IDLE;
          if (state_q == WR_WAIT) pkt_cnt_d = pkt_cnt_q + 16'd1;
        end else if (!seen_busy_q && (timer_q == TO_LAST)) begin
          state_d  = IDLE;
          err_d[2] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      seen_busy_q <= 1'b0;
      rd_wr_en_q  <= 2'b00;
      rd_wr_num_q <= '0;
      pkt_cnt_q   <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      seen_busy_q <= seen_busy_d;
      rd_wr_en_q  <= rd_wr_en_d;
      rd_wr_num_q <= rd_wr_num_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= read_data;
  end

  assign write_data = (count_q == '0) ? '0 : mem_q[rp_q];
  assign rd_wr_en   = rd_wr_en_q;
  assign rd_wr_num  = rd_wr_num_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_usb_echo_ctrl.sv
// Directed bench for usb_echo_ctrl: the bench plays usb_ctrl by hand and checks
// requests, echoed data, packet count and error flags against fixed expectations.
module tb_usb_echo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        echo_en;
  logic        usb_is_busy;
  logic [15:0] read_data;
  logic        output_valid;
  logic        write_ready;
  logic [10:0] rd_wr_num;
  logic [1:0]  rd_wr_en;
  logic [15:0] write_data;
  logic [15:0] pkt_cnt;
  logic [2:0]  err;

  int checks = 0;
  int errors = 0;
  logic [15:0] vec [4];

  usb_echo_ctrl #(
    .PKT_WORDS(4),
    .ADDR_W   (4),
    .TO_CYC   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .echo_en     (echo_en),
    .usb_is_busy (usb_is_busy),
    .read_data   (read_data),
    .output_valid(output_valid),
    .write_ready (write_ready),
    .rd_wr_num   (rd_wr_num),
    .rd_wr_en    (rd_wr_en),
    .write_data  (write_data),
    .pkt_cnt     (pkt_cnt),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_en(input string tag, input logic [1:0] exp);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rd_wr_en != 2'b00) break;
    end
    chk(tag, {14'b0, rd_wr_en}, {14'b0, exp});
  endtask

  // Called with the block in RD_REQ; returns right after the done edge.
  task automatic serve_read(input string tag, input int n);
    usb_is_busy = 1'b1;
    tick();
    chk({tag, "_req_one_cycle"}, {14'b0, rd_wr_en}, 16'h0000);
    tick();
    for (int i = 0; i < n; i++) begin
      output_valid = 1'b1;
      read_data    = vec[i];
      tick();
    end
    output_valid = 1'b0;
    read_data    = '0;
    usb_is_busy  = 1'b0;
    tick();
  endtask

  // Called with the block in WR_REQ; pops n words, checking each head word.
  task automatic serve_write(input string tag, input int n);
    usb_is_busy = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_wd%0d", tag, i), write_data, vec[i]);
      write_ready = 1'b1;
      tick();
      write_ready = 1'b0;
    end
    usb_is_busy = 1'b0;
    tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"},   {14'b0, rd_wr_en}, 16'h0000);
    chk({tag, "_num"},  {5'b0, rd_wr_num}, 16'h0000);
    chk({tag, "_wd"},   write_data,        16'h0000);
    chk({tag, "_pkt"},  pkt_cnt,           16'h0000);
    chk({tag, "_err"},  {13'b0, err},      16'h0000);
  endtask

  initial begin
    rst_n        = 1'b0;
    echo_en      = 1'b0;
    usb_is_busy  = 1'b0;
    read_data    = '0;
    output_valid = 1'b0;
    write_ready  = 1'b0;
    repeat (3) tick();
    chk_reset("rst");
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("idle_no_req", {14'b0, rd_wr_en}, 16'h0000);

    // Basic four-word echo with exact request timing
    echo_en = 1'b1;
    tick();
    chk("t1_rd_en",  {14'b0, rd_wr_en}, 16'h0002);
    chk("t1_rd_num", {5'b0, rd_wr_num}, 16'd4);
    vec = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    serve_read("t1", 4);
    chk("t1_gap", {14'b0, rd_wr_en}, 16'h0000);
    tick();
    chk("t1_wr_en",  {14'b0, rd_wr_en}, 16'h0001);
    chk("t1_wr_num", {5'b0, rd_wr_num}, 16'd4);
    serve_write("t1", 4);
    chk("t1_pkt",   pkt_cnt,    16'd1);
    chk("t1_empty", write_data, 16'h0000);

    // Short host packet
    wait_en("t2_rd_en", 2'b10);
    vec = '{16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000};
    serve_read("t2", 2);
    wait_en("t2_wr_en", 2'b01);
    chk("t2_wr_num", {5'b0, rd_wr_num}, 16'd2);
    serve_write("t2", 2);
    chk("t2_pkt", pkt_cnt, 16'd2);
    echo_en = 1'b0;

    // Stalled write path: timeout then retry
    echo_en = 1'b1;
    wait_en("t3_rd_en", 2'b10);
    vec = '{16'h0011, 16'h0012, 16'h0013, 16'h0014};
    serve_read("t3", 4);
    echo_en = 1'b0;
    wait_en("t3_wr_en", 2'b01);
    repeat (10) tick();
    chk("t3_no_timeout_yet", {13'b0, err}, 16'h0000);
    repeat (7) tick();
    chk("t3_timeout", {13'b0, err}, 16'h0004);
    tick();
    chk("t3_retry_en", {14'b0, rd_wr_en}, 16'h0001);
    serve_write("t3", 4);
    chk("t3_pkt", pkt_cnt, 16'd3);

    // Overflow: 17 words into a 16-deep buffer
    for (int i = 0; i < 17; i++) begin
      output_valid = 1'b1;
      read_data    = 16'h0100 + 16'(i);
      tick();
    end
    output_valid = 1'b0;
    read_data    = '0;
    chk("t3_overflow", {13'b0, err}, 16'h0005);
    for (int p = 0; p < 4; p++) begin
      wait_en($sformatf("t3_drain%0d_en", p), 2'b01);
      chk($sformatf("t3_drain%0d_num", p), {5'b0, rd_wr_num}, 16'd4);
      for (int k = 0; k < 4; k++) vec[k] = 16'h0100 + 16'(4 * p + k);
      serve_write($sformatf("t3_drain%0d", p), 4);
    end
    chk("t3_drain_pkt",   pkt_cnt,    16'd7);
    chk("t3_drain_empty", write_data, 16'h0000);

    // Underflow on an empty buffer leaves pointers alone
    write_ready = 1'b1;
    tick();
    write_ready = 1'b0;
    chk("t4_underflow", {13'b0, err}, 16'h0007);
    chk("t4_wd_zero",   write_data,   16'h0000);
    output_valid = 1'b1;
    read_data    = 16'h5A5A;
    tick();
    output_valid = 1'b0;
    read_data    = '0;
    chk("t4_ptr_intact", write_data, 16'h5A5A);
    wait_en("t4_wr_en", 2'b01);
    chk("t4_wr_num", {5'b0, rd_wr_num}, 16'd1);
    vec[0] = 16'h5A5A;
    serve_write("t4", 1);
    chk("t4_pkt", pkt_cnt, 16'd8);

    // Reset mid read with two words buffered
    echo_en = 1'b1;
    wait_en("t5_rd_en", 2'b10);
    usb_is_busy = 1'b1;
    tick();
    tick();
    output_valid = 1'b1;
    read_data    = 16'hCCCC;
    tick();
    read_data    = 16'hDDDD;
    tick();
    output_valid = 1'b0;
    read_data    = '0;
    rst_n        = 1'b0;
    #1;
    chk_reset("t5_rst");
    usb_is_busy = 1'b0;
    echo_en     = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("t5_idle", {14'b0, rd_wr_en}, 16'h0000);
    echo_en = 1'b1;
    wait_en("t5_rd_en2", 2'b10);
    vec = '{16'hEEEE, 16'h1234, 16'h0000, 16'h0000};
    serve_read("t5", 2);
    echo_en = 1'b0;
    wait_en("t5_wr_en", 2'b01);
    chk("t5_wr_num", {5'b0, rd_wr_num}, 16'd2);
    serve_write("t5", 2);
    chk("t5_pkt",   pkt_cnt,    16'd1);
    chk("t5_empty", write_data, 16'h0000);

    // Packet counter wrap, preloaded near the top of its range
    force dut.pkt_cnt_q = 16'hFFFE;
    #1;
    release dut.pkt_cnt_q;
    for (int r = 0; r < 2; r++) begin
      output_valid = 1'b1;
      read_data    = 16'h0F0F + 16'(r);
      tick();
      output_valid = 1'b0;
      read_data    = '0;
      wait_en($sformatf("t6_wr%0d_en", r), 2'b01);
      vec[0] = 16'h0F0F + 16'(r);
      serve_write($sformatf("t6_wr%0d", r), 1);
      chk($sformatf("t6_pkt%0d", r), pkt_cnt, (r == 0) ? 16'hFFFF : 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
